// File: rtl/k_and_s_pkg.sv
// Shared definitions for the K&S datapath: instruction classes, opcodes,
// ALU operation encodings and the opcode decoder.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
  } decoded_instruction_type;

  localparam logic [7:0] OP_BRANCH = 8'h01;
  localparam logic [7:0] OP_BZERO  = 8'h02;
  localparam logic [7:0] OP_BNEG   = 8'h03;
  localparam logic [7:0] OP_BOV    = 8'h05;
  localparam logic [7:0] OP_BNOV   = 8'h06;
  localparam logic [7:0] OP_BNNEG  = 8'h0A;
  localparam logic [7:0] OP_BNZERO = 8'h0B;
  localparam logic [7:0] OP_LOAD   = 8'h81;
  localparam logic [7:0] OP_STORE  = 8'h82;
  localparam logic [7:0] OP_MOVE   = 8'h91;
  localparam logic [7:0] OP_ADD    = 8'hA1;
  localparam logic [7:0] OP_SUB    = 8'hA2;
  localparam logic [7:0] OP_AND    = 8'hA3;
  localparam logic [7:0] OP_OR     = 8'hA4;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Map the opcode byte to an instruction class; unknown opcodes are NOPs.
  function automatic decoded_instruction_type decode_opcode(input logic [7:0] op);
    case (op)
      OP_BRANCH: return I_BRANCH;
      OP_BZERO:  return I_BZERO;
      OP_BNEG:   return I_BNEG;
      OP_BOV:    return I_BOV;
      OP_BNOV:   return I_BNOV;
      OP_BNNEG:  return I_BNNEG;
      OP_BNZERO: return I_BNZERO;
      OP_LOAD:   return I_LOAD;
      OP_STORE:  return I_STORE;
      OP_MOVE:   return I_MOVE;
      OP_ADD:    return I_ADD;
      OP_SUB:    return I_SUB;
      OP_AND:    return I_AND;
      OP_OR:     return I_OR;
      OP_HALT:   return I_HALT;
      default:   return I_NOP;
    endcase
  endfunction

endpackage

// File: rtl/data_path_ula.sv
// Combinational ALU: add/sub/and/or with zero, negative, carry/borrow and
// two's-complement overflow flags.
module ula
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [1:0]        i_operation,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero,
  output logic              o_neg,
  output logic              o_unsigned_overflow,
  output logic              o_signed_overflow
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  // The extra top bit carries the carry-out (add) or borrow (sub).
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  // Select the result and overflow flags for the requested operation.
  always_comb begin
    o_result            = '0;
    o_unsigned_overflow = 1'b0;
    o_signed_overflow   = 1'b0;
    case (i_operation)
      ALU_ADD: begin
        o_result            = w_sum[MSB:0];
        o_unsigned_overflow = w_sum[DATA_W];
        o_signed_overflow   = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
      end
      ALU_SUB: begin
        o_result            = w_diff[MSB:0];
        o_unsigned_overflow = w_diff[DATA_W];
        o_signed_overflow   = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
      end
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);
  assign o_neg  = o_result[MSB];

endmodule

// File: rtl/data_path.sv
// K&S processor datapath: PC, IR, 4x16 register file, ALU and flag register,
// driven by strobes from an external control unit.
module data_path
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    write_reg_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic                    flags_reg_enable,
  input  logic [1:0]              operation,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in
);

  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_rf [4];
  logic              r_zero, r_neg, r_uov, r_sov;

  decoded_instruction_type w_dec;
  logic [1:0]        w_c, w_a, w_b;
  logic              w_b_zero;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_alu_b, w_alu_result;
  logic              w_alu_zero, w_alu_neg, w_alu_uov, w_alu_sov;
  logic              w_unused;

  assign w_dec      = decode_opcode(r_ir[15:8]);
  assign w_mem_addr = r_ir[ADDR_W-1:0];
  assign w_unused   = r_ir[7];

  // Register-field extraction; layout depends on the instruction class.
  always_comb begin
    w_c      = r_ir[5:4];
    w_a      = r_ir[3:2];
    w_b      = r_ir[1:0];
    w_b_zero = 1'b0;
    case (w_dec)
      I_MOVE: begin
        w_c      = r_ir[3:2];
        w_a      = r_ir[1:0];
        w_b_zero = 1'b1;
      end
      I_LOAD:  w_c = r_ir[6:5];
      I_STORE: w_a = r_ir[6:5];
      default: ;
    endcase
  end

  // Register reads are asynchronous, so the ALU sees pre-edge values even
  // when the destination register is also a source.
  assign w_alu_b             = w_b_zero ? '0 : r_rf[w_b];
  assign data_out            = r_rf[w_a];
  assign ram_addr            = addr_sel ? w_mem_addr : r_pc;
  assign decoded_instruction = w_dec;

  ula #(.DATA_W(DATA_W)) u_ula (
    .i_a                 (r_rf[w_a]),
    .i_b                 (w_alu_b),
    .i_operation         (operation),
    .o_result            (w_alu_result),
    .o_zero              (w_alu_zero),
    .o_neg               (w_alu_neg),
    .o_unsigned_overflow (w_alu_uov),
    .o_signed_overflow   (w_alu_sov)
  );

  // Program counter and instruction register; IR captures the word fetched
  // from the pre-edge PC even when PC advances on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
      r_ir <= '0;
    end else begin
      if (pc_enable) r_pc <= branch ? w_mem_addr : r_pc + 1'b1;
      if (ir_enable) r_ir <= data_in;
    end
  end

  // Register file write port: memory data for loads, ALU result otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_rf[i] <= '0;
    end else if (write_reg_enable) begin
      r_rf[w_c] <= c_sel ? data_in : w_alu_result;
    end
  end

  // Flag register latches the current ALU flags on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_uov  <= 1'b0;
      r_sov  <= 1'b0;
    end else if (flags_reg_enable) begin
      r_zero <= w_alu_zero;
      r_neg  <= w_alu_neg;
      r_uov  <= w_alu_uov;
      r_sov  <= w_alu_sov;
    end
  end

  assign zero_op           = r_zero;
  assign neg_op            = r_neg;
  assign unsigned_overflow = r_uov;
  assign signed_overflow   = r_sov;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path with an arithmetic reference model.
module tb_data_path;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, flags_reg_enable;
  logic [1:0] operation;
  decoded_instruction_type decoded_instruction;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;
  logic [4:0]  ram_addr;
  logic [15:0] data_out, data_in;

  data_path #(.DATA_W(16), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .write_reg_enable(write_reg_enable), .addr_sel(addr_sel),
    .c_sel(c_sel), .flags_reg_enable(flags_reg_enable), .operation(operation),
    .decoded_instruction(decoded_instruction), .zero_op(zero_op), .neg_op(neg_op),
    .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
    .ram_addr(ram_addr), .data_out(data_out), .data_in(data_in)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference state
  logic [4:0]  m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_r [4];
  bit          m_z, m_n, m_uo, m_so;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic decoded_instruction_type exp_dec(input logic [15:0] ir);
    case (ir[15:8])
      8'h01: return I_BRANCH;  8'h02: return I_BZERO;  8'h03: return I_BNEG;
      8'h05: return I_BOV;     8'h06: return I_BNOV;   8'h0A: return I_BNNEG;
      8'h0B: return I_BNZERO;  8'h81: return I_LOAD;   8'h82: return I_STORE;
      8'h91: return I_MOVE;    8'hA1: return I_ADD;    8'hA2: return I_SUB;
      8'hA3: return I_AND;     8'hA4: return I_OR;     8'hFF: return I_HALT;
      default: return I_NOP;
    endcase
  endfunction

  function automatic int fld_a(input logic [15:0] ir);
    if (ir[15:8] == 8'h82) return int'(ir[6:5]);
    if (ir[15:8] == 8'h91) return int'(ir[1:0]);
    return int'(ir[3:2]);
  endfunction

  function automatic int fld_c(input logic [15:0] ir);
    if (ir[15:8] == 8'h81) return int'(ir[6:5]);
    if (ir[15:8] == 8'h91) return int'(ir[3:2]);
    return int'(ir[5:4]);
  endfunction

  // Arithmetic in wide integers; overflow means the true result does not fit.
  task automatic alu_model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output bit z, output bit n,
                           output bit uo, output bit so);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    uo = 1'b0; so = 1'b0; ur = 0;
    case (op)
      2'd0: begin ur = ua + ub; sr = sa + sb; uo = (ur > 65535); so = (sr > 32767) || (sr < -32768); end
      2'd1: begin ur = ua - ub; sr = sa - sb; uo = (ua < ub);    so = (sr > 32767) || (sr < -32768); end
      2'd2: ur = int'(a & b);
      default: ur = int'(a | b);
    endcase
    res = ur[15:0];
    z = (res == 16'h0);
    n = res[15];
  endtask

  task automatic model_reset();
    m_pc = '0; m_ir = '0;
    for (int i = 0; i < 4; i++) m_r[i] = '0;
    m_z = 0; m_n = 0; m_uo = 0; m_so = 0;
  endtask

  // One clock with the given strobes; the model advances from pre-edge state.
  task automatic cycle(input bit pe, input bit ie, input bit br, input bit wre, input bit cs,
                       input bit fe, input bit as, input logic [1:0] op, input logic [15:0] din);
    logic [15:0] res, bval;
    bit z, n, uo, so;
    pc_enable = pe; ir_enable = ie; branch = br; write_reg_enable = wre;
    c_sel = cs; flags_reg_enable = fe; addr_sel = as; operation = op; data_in = din;
    @(posedge clk);
    bval = (exp_dec(m_ir) == I_MOVE) ? 16'h0 : m_r[m_ir[1:0]];
    alu_model(op, m_r[fld_a(m_ir)], bval, res, z, n, uo, so);
    if (wre) m_r[fld_c(m_ir)] = cs ? din : res;
    if (fe) begin m_z = z; m_n = n; m_uo = uo; m_so = so; end
    if (pe) m_pc = br ? m_ir[4:0] : m_pc + 5'd1;
    if (ie) m_ir = din;
    #1;
    pc_enable = 0; ir_enable = 0; branch = 0; write_reg_enable = 0;
    c_sel = 0; flags_reg_enable = 0;
  endtask

  task automatic fetch(input logic [15:0] instr, input bit pe);
    cycle(pe, 1, 0, 0, 0, 0, 0, 2'd0, instr);
  endtask

  task automatic load_reg(input logic [1:0] n, input logic [15:0] val);
    fetch({8'h81, 1'b0, n, 5'd0}, 0);
    cycle(0, 0, 0, 1, 1, 0, 0, 2'd0, val);
  endtask

  task automatic peek(input logic [1:0] n, input logic [15:0] exp, input string name);
    fetch({8'h82, 1'b0, n, 5'd0}, 0);
    chk(name, 32'(data_out), 32'(exp));
  endtask

  task automatic alu_op(input logic [15:0] instr, input logic [1:0] op, input bit wre);
    fetch(instr, 0);
    cycle(0, 0, 0, wre, 0, 1, 0, op, 16'h0);
  endtask

  // Every settled cycle: compare all outputs against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("decode",   32'(decoded_instruction), 32'(exp_dec(m_ir)));
      chk("ram_addr", 32'(ram_addr), 32'(addr_sel ? m_ir[4:0] : m_pc));
      chk("data_out", 32'(data_out), 32'(m_r[fld_a(m_ir)]));
      chk("zero",     32'(zero_op), 32'(m_z));
      chk("neg",      32'(neg_op), 32'(m_n));
      chk("uov",      32'(unsigned_overflow), 32'(m_uo));
      chk("sov",      32'(signed_overflow), 32'(m_so));
    end
  end

  logic [7:0] ops [20] = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h0A, 8'h0B, 8'h81, 8'h82,
                           8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF, 8'h00, 8'h04, 8'h80,
                           8'hC0, 8'hFE};

  initial begin
    rst_n = 0; branch = 0; pc_enable = 0; ir_enable = 0; write_reg_enable = 0;
    addr_sel = 0; c_sel = 0; flags_reg_enable = 0; operation = 0; data_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk_en = 1;

    // Reset state
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_decode",   32'(decoded_instruction), 32'(I_NOP));
    chk("rst_flags",    32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'h0);
    chk("rst_data_out", 32'(data_out), 32'h0);

    // Fetch LOAD with PC advance, then load R0
    cycle(1, 1, 0, 0, 0, 0, 0, 2'd0, 16'h8105);
    chk("load_decode", 32'(decoded_instruction), 32'(I_LOAD));
    chk("pc_after_fetch", 32'(ram_addr), 32'd1);
    addr_sel = 1; #1;
    chk("load_mem_addr", 32'(ram_addr), 32'd5);
    cycle(0, 0, 0, 1, 1, 0, 1, 2'd0, 16'h1234);
    addr_sel = 0;
    peek(0, 16'h1234, "load_r0");

    // Signed overflow on add
    load_reg(0, 16'h7FFF); load_reg(1, 16'h0001);
    alu_op(16'hA124, 2'd0, 1);
    chk("add_flags", 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'b0101);
    peek(2, 16'h8000, "add_r2");

    // Borrow on sub (a=R1=0, b=R0=1), then AND clears overflow flags
    load_reg(0, 16'h0001); load_reg(1, 16'h0000);
    alu_op(16'hA224, 2'd1, 1);
    chk("sub_flags", 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'b0110);
    peek(2, 16'hFFFF, "sub_r2");
    alu_op(16'hA324, 2'd2, 0);
    chk("and_flags", 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'b1000);

    // Signed overflow on sub, carry-out to zero on add, OR
    load_reg(1, 16'h8000);
    alu_op(16'hA224, 2'd1, 1);
    chk("subov_flags", 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'b0001);
    load_reg(1, 16'hFFFF);
    alu_op(16'hA124, 2'd0, 1);
    chk("carry_flags", 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'b1010);
    load_reg(0, 16'h0F00); load_reg(1, 16'h00F0);
    alu_op(16'hA424, 2'd3, 1);
    peek(2, 16'h0FF0, "or_r2");
    cycle(0, 0, 0, 1, 0, 0, 0, 2'd1, 16'h0);   // write without flag update

    // PC wrap and branching
    fetch(16'h011F, 0);
    cycle(1, 0, 1, 0, 0, 0, 0, 2'd0, 16'h0);
    chk("pc_31", 32'(ram_addr), 32'd31);
    cycle(1, 0, 0, 0, 0, 0, 0, 2'd0, 16'h0);
    chk("pc_wrap", 32'(ram_addr), 32'd0);
    fetch(16'h0114, 0);
    chk("branch_decode", 32'(decoded_instruction), 32'(I_BRANCH));
    cycle(1, 0, 1, 0, 0, 0, 0, 2'd0, 16'h0);
    chk("pc_branch", 32'(ram_addr), 32'd20);
    cycle(0, 0, 1, 0, 0, 0, 0, 2'd0, 16'h0);
    chk("pc_branch_hold", 32'(ram_addr), 32'd20);

    // STORE addressing and MOVE
    load_reg(2, 16'hBEEF);
    fetch(16'h8243, 0);
    addr_sel = 1; #1;
    chk("store_addr", 32'(ram_addr), 32'd3);
    chk("store_data", 32'(data_out), 32'hBEEF);
    addr_sel = 0;
    fetch(16'h9106, 0);
    chk("move_decode", 32'(decoded_instruction), 32'(I_MOVE));
    cycle(0, 0, 0, 1, 0, 0, 0, 2'd0, 16'h0);
    peek(1, 16'hBEEF, "move_r1");

    // Read-before-write: R1 <= R1 + R1
    alu_op(16'hA115, 2'd0, 1);
    peek(1, 16'h7DDE, "rbw_r1");
    chk("rbw_flags", 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'b0011);

    // Decode sweep with fetch+PC advance, then HALT hold
    for (int i = 0; i < 20; i++) fetch({ops[i], 8'h00}, 1);
    chk("unknown_decode", 32'(decoded_instruction), 32'(I_NOP));
    fetch(16'hFF00, 0);
    chk("halt_decode", 32'(decoded_instruction), 32'(I_HALT));
    repeat (4) cycle(0, 0, 0, 0, 0, 0, 0, 2'd0, 16'h5A5A);

    // Reset during a LOAD write cycle
    load_reg(3, 16'h1111);
    fetch(16'h8160, 1);
    @(negedge clk);
    write_reg_enable = 1; c_sel = 1; data_in = 16'h5555; addr_sel = 0;
    #1 rst_n = 0;
    model_reset();
    #1;
    chk("async_rst_addr",   32'(ram_addr), 32'h0);
    chk("async_rst_decode", 32'(decoded_instruction), 32'(I_NOP));
    @(posedge clk); #1;
    write_reg_enable = 0; c_sel = 0;
    rst_n = 1;
    chk("post_rst_flags", 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'h0);
    chk("post_rst_data_out", 32'(data_out), 32'h0);
    for (int i = 0; i < 4; i++) peek(2'(i), 16'h0, "post_rst_reg");
    chk("post_rst_pc", 32'(ram_addr), 32'h0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
